// File: rtl/dma_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dma_arb_pkg
// Description : Shared types and defaults for the DMA request arbiter:
//               FSM state encoding, default widths and a wrap helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dma_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        STREAM = 2'd2,
        ZLEN   = 2'd3
    } arb_state_t;

    localparam int c_N_REQ  = 4;
    localparam int c_ADDR_W = 27;
    localparam int c_DATA_W = 512;
    localparam int c_IDX_W  = 3;

    // Next index after idx in a ring of n entries.
    function automatic int wrap_next(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dma_req_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : dma_req_arbiter_if
// Description : Bundle of the per-layer request/stream signals and the DMA
//               engine read-port signals handled by the arbiter.
//               slave  = arbiter side, master = layers + engine side.
// Revision    : 1.0 - initial release
// ============================================================================
interface dma_req_arbiter_if import dma_arb_pkg::*; #(
    parameter int N_REQ  = c_N_REQ,
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W,
    parameter int IDX_W  = c_IDX_W
) ();
    logic [N_REQ-1:0]        lyr_req;
    logic [N_REQ*ADDR_W-1:0] lyr_start_addr;
    logic [N_REQ*ADDR_W-1:0] lyr_length;
    logic [N_REQ-1:0]        lyr_ack;
    logic [N_REQ-1:0]        lyr_dout_en;
    logic [N_REQ-1:0]        lyr_dout_eop;
    logic [DATA_W-1:0]       lyr_dout;

    logic                    dma_engineer_req;
    logic                    dma_engineer_ack;
    logic [ADDR_W-1:0]       dma_engineer_start_addr;
    logic [ADDR_W-1:0]       dma_engineer_length;
    logic                    dma_engineer_dout_en;
    logic                    dma_engineer_dout_eop;
    logic [DATA_W-1:0]       dma_engineer_dout;

    logic [IDX_W-1:0]        grant_idx;
    logic                    busy;
    logic                    err_zero_len;

    modport slave (
        input  lyr_req, lyr_start_addr, lyr_length,
               dma_engineer_ack, dma_engineer_dout_en, dma_engineer_dout_eop, dma_engineer_dout,
        output lyr_ack, lyr_dout_en, lyr_dout_eop, lyr_dout,
               dma_engineer_req, dma_engineer_start_addr, dma_engineer_length,
               grant_idx, busy, err_zero_len
    );

    modport master (
        output lyr_req, lyr_start_addr, lyr_length,
               dma_engineer_ack, dma_engineer_dout_en, dma_engineer_dout_eop, dma_engineer_dout,
        input  lyr_ack, lyr_dout_en, lyr_dout_eop, lyr_dout,
               dma_engineer_req, dma_engineer_start_addr, dma_engineer_length,
               grant_idx, busy, err_zero_len
    );
endinterface
`default_nettype wire

// File: rtl/dma_req_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Combinational requester picker. Round-robin search starting
//               at i_ptr and wrapping upward; with DMA_ARB_FIXED_PRIO_EN
//               defined it becomes a lowest-index-wins priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 3
) (
    input  wire logic [N_REQ-1:0] i_req,
    input  wire logic [IDX_W-1:0] i_ptr,
    output logic      [N_REQ-1:0] o_grant_oh,
    output logic      [IDX_W-1:0] o_grant_idx
);

`ifdef DMA_ARB_FIXED_PRIO_EN
    logic w_unused_ptr;
    assign w_unused_ptr = ^i_ptr;
`endif

    // First set request found walking up from the start point, with wrap.
    always_comb begin
        int  j;
        logic w_found;
        o_grant_oh  = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        j           = 0;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef DMA_ARB_FIXED_PRIO_EN
            j = k;
`else
            j = int'(i_ptr) + k;
            if (j >= N_REQ) j = j - N_REQ;
`endif
            if (!w_found && i_req[j]) begin
                w_found       = 1'b1;
                o_grant_oh[j] = 1'b1;
                o_grant_idx   = IDX_W'(j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dma_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dma_req_arbiter
// Description : Shares the DMA engine read port among N_REQ layer
//               controllers: picks one requester, forwards its latched
//               address/length to the engine, routes the returning beat
//               stream to that layer only.
//               Option macro: DMA_ARB_FIXED_PRIO_EN (fixed priority,
//               lowest index wins; round-robin pointer held at 0).
// Revision    : 1.0 - initial release
// ============================================================================
module dma_req_arbiter import dma_arb_pkg::*; #(
    parameter int N_REQ  = c_N_REQ,
    parameter int ADDR_W = c_ADDR_W,
    parameter int DATA_W = c_DATA_W,
    parameter int IDX_W  = c_IDX_W
) (
    input wire logic         clk,
    input wire logic         rst,
    dma_req_arbiter_if.slave bus
);

    arb_state_t        r_state, w_next_state;
    logic [IDX_W-1:0]  r_grant_idx;
    logic [ADDR_W-1:0] r_addr, r_len;
    logic              r_err;
    logic [IDX_W-1:0]  w_pick_ptr, w_pick_idx;
    logic [N_REQ-1:0]  w_pick_oh, w_grant_oh;
    logic [N_REQ-1:0]  w_ack, w_dout_en, w_dout_eop;
    logic [ADDR_W-1:0] w_addr_arr [2**IDX_W];
    logic [ADDR_W-1:0] w_len_arr  [2**IDX_W];
    logic              w_fwd, w_done, w_eop_beat;

    // Unpack per-layer address/length; pad to a power of two so the grant index addresses it directly.
    generate
        for (genvar gi = 0; gi < 2**IDX_W; gi++) begin : g_slot
            if (gi < N_REQ) begin : g_used
                assign w_addr_arr[gi] = bus.lyr_start_addr[gi*ADDR_W +: ADDR_W];
                assign w_len_arr[gi]  = bus.lyr_length[gi*ADDR_W +: ADDR_W];
            end else begin : g_pad
                assign w_addr_arr[gi] = '0;
                assign w_len_arr[gi]  = '0;
            end
        end
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_oh
            assign w_grant_oh[gi] = (r_grant_idx == IDX_W'(gi));
        end
    endgenerate

    rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .i_req       (bus.lyr_req),
        .i_ptr       (w_pick_ptr),
        .o_grant_oh  (w_pick_oh),
        .o_grant_idx (w_pick_idx)
    );

    // Beats are forwarded in STREAM and also on the ack cycle, where the first beat may coincide.
    assign w_fwd      = (r_state == STREAM) || (r_state == ISSUE && bus.dma_engineer_ack);
    assign w_eop_beat = bus.dma_engineer_dout_en && bus.dma_engineer_dout_eop;
    assign w_done     = (r_state == ZLEN) || (w_fwd && w_eop_beat);

    // Next-state decode and per-layer ack/beat routing.
    always_comb begin
        w_next_state = r_state;
        w_ack        = '0;
        w_dout_en    = '0;
        w_dout_eop   = '0;
        case (r_state)
            IDLE:    if (|w_pick_oh)
                         w_next_state = (w_len_arr[w_pick_idx] == '0) ? ZLEN : ISSUE;
            ISSUE:   if (bus.dma_engineer_ack)
                         w_next_state = w_eop_beat ? IDLE : STREAM;
            STREAM:  if (w_eop_beat) w_next_state = IDLE;
            ZLEN:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
        if ((r_state == ISSUE && bus.dma_engineer_ack) || r_state == ZLEN)
            w_ack = w_grant_oh;
        if (w_fwd && bus.dma_engineer_dout_en)
            w_dout_en = w_grant_oh;
        if (w_fwd && bus.dma_engineer_dout_eop)
            w_dout_eop = w_grant_oh;
    end

    // State, grant latch and sticky zero-length flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_grant_idx <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == IDLE && |w_pick_oh) begin
                r_grant_idx <= w_pick_idx;
                r_addr      <= w_addr_arr[w_pick_idx];
                r_len       <= w_len_arr[w_pick_idx];
            end
            if (r_state == ZLEN)
                r_err <= 1'b1;
        end
    end

`ifdef DMA_ARB_FIXED_PRIO_EN
    assign w_pick_ptr = '0;
`else
    logic [IDX_W-1:0] r_rr_ptr;

    // Round-robin pointer moves past the layer whose transfer just finished.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rr_ptr <= '0;
        else if (w_done)
            r_rr_ptr <= IDX_W'(wrap_next(int'(r_grant_idx), N_REQ));
    end

    assign w_pick_ptr = r_rr_ptr;
`endif

    assign bus.lyr_ack                 = w_ack;
    assign bus.lyr_dout_en             = w_dout_en;
    assign bus.lyr_dout_eop            = w_dout_eop;
    assign bus.lyr_dout                = bus.dma_engineer_dout[DATA_W-1:0];
    assign bus.dma_engineer_req        = (r_state == ISSUE);
    assign bus.dma_engineer_start_addr = r_addr;
    assign bus.dma_engineer_length     = r_len;
    assign bus.grant_idx               = r_grant_idx;
    assign bus.busy                    = (r_state != IDLE);
    assign bus.err_zero_len            = r_err;

endmodule
`default_nettype wire

// File: tb/tb_dma_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_req_arbiter
// Description : Directed self-checking bench for dma_req_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dma_req_arbiter;
    localparam int N_REQ  = 4;
    localparam int ADDR_W = 27;
    localparam int DATA_W = 512;
    localparam int IDX_W  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   beat_cnt [N_REQ];

    dma_req_arbiter_if #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    dma_req_arbiter #(.N_REQ(N_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.lyr_req               = '0;
        bus.lyr_start_addr        = '0;
        bus.lyr_length            = '0;
        bus.dma_engineer_ack      = 1'b0;
        bus.dma_engineer_dout_en  = 1'b0;
        bus.dma_engineer_dout_eop = 1'b0;
        bus.dma_engineer_dout     = '0;
    endtask

    task automatic set_layer(input int i, input logic [ADDR_W-1:0] addr, input logic [ADDR_W-1:0] len);
        bus.lyr_start_addr[i*ADDR_W +: ADDR_W] = addr;
        bus.lyr_length[i*ADDR_W +: ADDR_W]     = len;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // Waits for the engine request, acks it and streams len beats, checking routing.
    task automatic run_xfer(input int g, input int len, input logic [ADDR_W-1:0] addr,
                            input bit coincide, input logic [N_REQ-1:0] req_after_ack);
        logic [N_REQ-1:0] oh;
        logic [31:0]      word;
        logic [DATA_W-1:0] data;
        int waited;
        int done;
        oh = '0;
        oh[g] = 1'b1;
        waited = 0;
        while (bus.dma_engineer_req !== 1'b1 && waited < 16) begin
            tick();
            waited++;
        end
        if (bus.dma_engineer_req !== 1'b1) begin
            check("req_timeout", 0, 1);
            return;
        end
        check("grant_idx", bus.grant_idx, g);
        check("eng_addr", bus.dma_engineer_start_addr, addr);
        check("eng_len", bus.dma_engineer_length, len);
        check("ack_before", bus.lyr_ack, 0);
        bus.dma_engineer_ack = 1'b1;
        done = 0;
        if (coincide) begin
            word = 32'(g * 256);
            data = {16{word}};
            bus.dma_engineer_dout_en  = 1'b1;
            bus.dma_engineer_dout_eop = (len == 1);
            bus.dma_engineer_dout     = data;
        end
        #1;
        check("lyr_ack", bus.lyr_ack, oh);
        if (coincide) begin
            check("beat_on_ack", bus.lyr_dout_en, oh);
            for (int i = 0; i < N_REQ; i++) if (bus.lyr_dout_en[i]) beat_cnt[i]++;
            done = 1;
        end
        tick();
        bus.dma_engineer_ack      = 1'b0;
        bus.dma_engineer_dout_en  = 1'b0;
        bus.dma_engineer_dout_eop = 1'b0;
        bus.lyr_req               = req_after_ack;
        #1;
        check("req_dropped", bus.dma_engineer_req, 0);
        check("ack_single", bus.lyr_ack, 0);
        while (done < len) begin
            word = 32'(g * 256 + done);
            data = {16{word}};
            bus.dma_engineer_dout_en  = 1'b1;
            bus.dma_engineer_dout_eop = (done == len - 1);
            bus.dma_engineer_dout     = data;
            #1;
            check("dout_en", bus.lyr_dout_en, oh);
            check("dout_eop", bus.lyr_dout_eop, (done == len - 1) ? oh : '0);
            check("dout", bus.lyr_dout, data);
            for (int i = 0; i < N_REQ; i++) if (bus.lyr_dout_en[i]) beat_cnt[i]++;
            tick();
            done++;
        end
        bus.dma_engineer_dout_en  = 1'b0;
        bus.dma_engineer_dout_eop = 1'b0;
        #1;
        check("idle_after", bus.busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order [5];
        exp_order = '{0, 1, 2, 3, 0};

        // Reset state
        do_reset();
        check("rst_busy", bus.busy, 0);
        check("rst_grant", bus.grant_idx, 0);
        check("rst_req", bus.dma_engineer_req, 0);
        check("rst_addr", bus.dma_engineer_start_addr, 0);
        check("rst_len", bus.dma_engineer_length, 0);
        check("rst_err", bus.err_zero_len, 0);
        check("rst_ack", bus.lyr_ack, 0);
        check("rst_en", bus.lyr_dout_en, 0);

        // Engine beats while idle are dropped
        bus.dma_engineer_dout_en  = 1'b1;
        bus.dma_engineer_dout_eop = 1'b1;
        #1;
        check("drop_idle_en", bus.lyr_dout_en, 0);
        check("drop_idle_eop", bus.lyr_dout_eop, 0);
        bus.dma_engineer_dout_en  = 1'b0;
        bus.dma_engineer_dout_eop = 1'b0;
        tick();

        // Single requester, layer 1
        set_layer(1, 1764, 1);
        bus.lyr_req = 4'b0010;
        #1;
        check("req_lat0", bus.dma_engineer_req, 0);
        tick();
        check("req_lat1", bus.dma_engineer_req, 1);
        check("busy_issue", bus.busy, 1);
        run_xfer(1, 1, 1764, 1'b0, 4'b0000);
        check("grant_hold", bus.grant_idx, 1);

`ifdef DMA_ARB_FIXED_PRIO_EN
        // Fixed priority: layer 1 beats layer 3 every time
        do_reset();
        set_layer(1, 11, 1);
        set_layer(3, 33, 1);
        bus.lyr_req = 4'b1010;
        tick();
        for (int k = 0; k < 3; k++) run_xfer(1, 1, 11, 1'b0, 4'b1010);
        bus.lyr_req = '0;
        tick();
`else
        // All four requesting, len 2 each: round-robin order 0,1,2,3,0
        do_reset();
        for (int i = 0; i < N_REQ; i++) begin
            set_layer(i, 27'(100 * i + 7), 2);
            beat_cnt[i] = 0;
        end
        bus.lyr_req = 4'b1111;
        tick();
        for (int k = 0; k < 5; k++)
            run_xfer(exp_order[k], 2, 27'(100 * exp_order[k] + 7), (k == 2), (k == 4) ? 4'b0000 : 4'b1111);
        check("beats_l0", beat_cnt[0], 4);
        check("beats_l1", beat_cnt[1], 2);
        check("beats_l2", beat_cnt[2], 2);
        check("beats_l3", beat_cnt[3], 2);
`endif

        // Layer 2 drops its request after the grant; latched address is used
        do_reset();
        set_layer(2, 5000, 3);
        bus.lyr_req = 4'b0100;
        tick();
        bus.lyr_req = 4'b0000;
        set_layer(2, 9999, 7);
        tick();
        tick();
        run_xfer(2, 3, 5000, 1'b0, 4'b0000);

        // Zero-length request on layer 3
        do_reset();
        set_layer(3, 777, 0);
        bus.lyr_req = 4'b1000;
        tick();
        check("zlen_ack", bus.lyr_ack, 4'b1000);
        check("zlen_noreq", bus.dma_engineer_req, 0);
        check("zlen_grant", bus.grant_idx, 3);
        set_layer(0, 42, 1);
        bus.lyr_req = 4'b1001;
        tick();
        check("zlen_ack_once", bus.lyr_ack, 0);
        check("zlen_err", bus.err_zero_len, 1);
        check("zlen_noreq2", bus.dma_engineer_req, 0);
        check("zlen_idle", bus.busy, 0);
        bus.lyr_req = 4'b1001;
        tick();
        bus.lyr_req = 4'b0000;
        run_xfer(0, 1, 42, 1'b1, 4'b0000);
        check("err_sticky", bus.err_zero_len, 1);

        // Asynchronous reset during STREAM
        do_reset();
        set_layer(2, 300, 1);
        bus.lyr_req = 4'b0100;
        tick();
        run_xfer(2, 1, 300, 1'b0, 4'b0000);
        set_layer(3, 400, 4);
        bus.lyr_req = 4'b1000;
        tick();
        check("pre_rst_req", bus.dma_engineer_req, 1);
        bus.dma_engineer_ack = 1'b1;
        tick();
        bus.dma_engineer_ack     = 1'b0;
        bus.lyr_req              = 4'b0000;
        bus.dma_engineer_dout_en = 1'b1;
        #1;
        check("pre_rst_en", bus.lyr_dout_en, 4'b1000);
        #2;
        rst = 1'b1;
        #1;
        check("arst_busy", bus.busy, 0);
        check("arst_en", bus.lyr_dout_en, 0);
        check("arst_grant", bus.grant_idx, 0);
        check("arst_addr", bus.dma_engineer_start_addr, 0);
        check("arst_req", bus.dma_engineer_req, 0);
        clear_inputs();
        tick();
        rst = 1'b0;
        set_layer(1, 200, 1);
        set_layer(3, 400, 1);
        bus.lyr_req = 4'b1010;
        tick();
        run_xfer(1, 1, 200, 1'b0, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
